// File: rtl/ddc_pkg.sv
// Shared constants and types for the DDC frame packer.
package ddc_pkg;

  localparam int unsigned DDC_WORDS  = 32;
  localparam int unsigned DDC_DATA_W = 32;
  localparam int unsigned DDC_TIME_W = 26;

  typedef logic [DDC_DATA_W-1:0] ddc_word_t;

  // Word i sits at bits [32i+31:32i] when the frame is viewed as a flat vector.
  typedef ddc_word_t [DDC_WORDS-1:0] ddc_frame_t;

  typedef enum logic {
    FILL,
    FULL
  } fill_state_t;

endpackage

// File: rtl/ddc_ack_detect.sv
// Turns each toggle of the HPS acknowledge PIO bit into a one-cycle ack pulse.
module ddc_ack_detect (
  input  logic clk,
  input  logic hps_read_bit,
  output logic ack
);

  logic hist_q;

  // History always tracks the input; during reset this preloads it, so no spurious ack.
  always_ff @(posedge clk) begin
    hist_q <= hps_read_bit;
  end

  assign ack = hps_read_bit ^ hist_q;

endmodule

// File: rtl/ddc_frame_packer.sv
// Packs a strobed sample stream into double-buffered frames for the HPS PIO bank.
// Optional partial-frame flush on idle is enabled by defining DDC_FRAME_FLUSH_EN.
module ddc_frame_packer
  import ddc_pkg::*;
#(
  parameter int unsigned       WORDS       = DDC_WORDS,
  parameter int unsigned       DATA_W      = DDC_DATA_W,
  parameter int unsigned       TIME_W      = DDC_TIME_W,
  parameter int unsigned       SEQ_W       = 8,
  parameter int unsigned       DROP_W      = 16,
  parameter int unsigned       FLUSH_TICKS = 1000000,
  parameter logic [TIME_W-1:0] TIME_INIT   = '0
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [DATA_W-1:0]       sample_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    hps_read_bit,
  output logic [WORDS*DATA_W-1:0] ddc_data,
  output logic [TIME_W-1:0]       ddc_time_out,
  output logic                    frame_ready,
  output logic [SEQ_W-1:0]        frame_seq,
  output logic [5:0]              frame_words,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam logic [5:0]  FULL_WORDS = 6'(WORDS);

  fill_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       fill_words_q, fill_words_d;

  logic [WORDS-1:0][DATA_W-1:0] fill_q;
  logic [WORDS-1:0][DATA_W-1:0] pub_data;
  logic [WORDS-1:0][DATA_W-1:0] data_q;
  logic [TIME_W-1:0]            time_q, stamp_q, time_out_q;
  logic                         ready_q;
  logic [SEQ_W-1:0]             seq_q;
  logic [5:0]                   words_q;
  logic [DROP_W-1:0]            drop_q;

  logic ack, ack_ok, accept, publish, flush_due;

  ddc_ack_detect u_ack_detect (
    .clk          (clk_clk),
    .hps_read_bit (hps_read_bit),
    .ack          (ack)
  );

  assign accept  = sample_valid && (state_q == FILL);
  assign ack_ok  = ack && ready_q;
  // Publish waits for the slot to be freed by an earlier edge, never the ack edge itself.
  assign publish = (state_q == FULL) && !ready_q;

`ifdef DDC_FRAME_FLUSH_EN
  localparam int unsigned IDLE_W = $clog2(FLUSH_TICKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TICKS - 1);

  logic [IDLE_W-1:0] idle_q;

  // Idle counter: cleared by each accepted sample, saturates once the flush point is reached.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || accept) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign flush_due = (idx_q != '0) && (idle_q == IDLE_LAST) && !sample_valid;

  // Words beyond the partial-frame count publish as zero.
  always_comb begin
    pub_data = fill_q;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (6'(i) >= fill_words_q) begin
        pub_data[i] = '0;
      end
    end
  end
`else
  logic unused_flush_ticks;
  assign unused_flush_ticks = ^FLUSH_TICKS;
  assign flush_due = 1'b0;

  // Every word is rewritten each frame, so the fill array publishes as-is.
  always_comb begin
    pub_data = fill_q;
  end
`endif

  // Fill FSM next state: count words in FILL, hold in FULL until the slot is free.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fill_words_d = fill_words_q;
    unique case (state_q)
      FILL: begin
        if (sample_valid) begin
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_d      = FULL;
            idx_d        = '0;
            fill_words_d = FULL_WORDS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (flush_due) begin
          state_d      = FULL;
          idx_d        = '0;
          fill_words_d = 6'(idx_q);
        end
      end
      FULL: begin
        if (publish) begin
          state_d = FILL;
        end
      end
    endcase
  end

  // Control state, time counter and published-slot registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= FILL;
      idx_q        <= '0;
      fill_words_q <= '0;
      time_q       <= TIME_INIT;
      stamp_q      <= '0;
      ready_q      <= 1'b0;
      seq_q        <= '0;
      words_q      <= '0;
      drop_q       <= '0;
      data_q       <= '0;
      time_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fill_words_q <= fill_words_d;
      time_q       <= time_q + 1'b1;
      if (accept && (idx_q == '0)) begin
        stamp_q <= time_q;
      end
      if ((state_q == FULL) && sample_valid && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
      if (ack_ok) begin
        ready_q <= 1'b0;
      end else if (publish) begin
        ready_q    <= 1'b1;
        data_q     <= pub_data;
        time_out_q <= stamp_q;
        words_q    <= fill_words_q;
        seq_q      <= seq_q + 1'b1;
      end
    end
  end

  // Fill array needs no reset: stale words are overwritten or masked before publish.
  always_ff @(posedge clk_clk) begin
    if (accept) begin
      fill_q[idx_q] <= sample_data;
    end
  end

  assign sample_ready = (state_q == FILL);
  assign ddc_data     = data_q;
  assign ddc_time_out = time_out_q;
  assign frame_ready  = ready_q;
  assign frame_seq    = seq_q;
  assign frame_words  = words_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_ddc_frame_packer.sv
// Scoreboard bench for ddc_frame_packer: stimulus pushes expected frames, a monitor
// pops and compares each time frame_seq advances. Flush case runs with DDC_FRAME_FLUSH_EN.
module tb_ddc_frame_packer;

  localparam logic [25:0] TINIT = 26'h3FFFFFE;

  logic           clk = 1'b0;
  logic           reset_reset;
  logic [31:0]    sample_data;
  logic           sample_valid;
  logic           sample_ready;
  logic           hps_read_bit;
  logic [1023:0]  ddc_data;
  logic [25:0]    ddc_time_out;
  logic           frame_ready;
  logic [7:0]     frame_seq;
  logic [5:0]     frame_words;
  logic [15:0]    drop_count;

  typedef struct {
    logic [1023:0] data;
    logic [25:0]   stamp;
    logic [5:0]    words;
    logic [7:0]    seq;
    int            pub_edge;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [25:0]   tm = '0;
  logic [7:0]    exp_seq = '0;
  logic [1023:0] cur_data;
  logic [25:0]   cur_stamp;

  ddc_frame_packer #(
    .FLUSH_TICKS (16),
    .TIME_INIT   (TINIT)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .hps_read_bit (hps_read_bit),
    .ddc_data     (ddc_data),
    .ddc_time_out (ddc_time_out),
    .frame_ready  (frame_ready),
    .frame_seq    (frame_seq),
    .frame_words  (frame_words),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Edge counter and reference free-running timer (value seen between edges).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    tm  <= reset_reset ? TINIT : tm + 26'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    sample_valid = v;
    sample_data  = d;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0);
  endtask

  // Sends n consecutive samples base..base+n-1, optionally toggling the ack on the last one.
  task automatic fill(input logic [31:0] base, input int n, input bit ack_last);
    cur_data = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) cur_stamp = tm;
      cur_data[32*i +: 32] = base + 32'(i);
      if (ack_last && (i == n - 1)) hps_read_bit = ~hps_read_bit;
      step(1'b1, base + 32'(i));
    end
  endtask

  task automatic expect_frame(input logic [5:0] words, input int pub_edge);
    exp_t e;
    exp_seq    = exp_seq + 8'd1;
    e.data     = cur_data;
    e.stamp    = cur_stamp;
    e.words    = words;
    e.seq      = exp_seq;
    e.pub_edge = pub_edge;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) idle(1);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_seq     = '0;
    reset_reset = 1'b0;
  endtask

  // Monitor: each new frame_seq value is one published frame; compare with the queue head.
  initial begin
    logic [7:0] last_seq;
    exp_t       e;
    int         bad;
    last_seq = '0;
    forever begin
      @(negedge clk);
      if (reset_reset) begin
        last_seq = '0;
      end else if (frame_seq != last_seq) begin
        last_seq = frame_seq;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(frame_seq), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_seq", 64'(frame_seq), 64'(e.seq));
          check("frame_words", 64'(frame_words), 64'(e.words));
          check("ddc_time_out", 64'(ddc_time_out), 64'(e.stamp));
          check("frame_ready_on_publish", 64'(frame_ready), 64'd1);
          if (e.pub_edge >= 0) check("publish_edge", 64'(cyc), 64'(e.pub_edge));
          tests++;
          bad = -1;
          for (int i = 0; i < 32; i++) begin
            if (bad < 0 && ddc_data[32*i +: 32] !== e.data[32*i +: 32]) bad = i;
          end
          if (bad >= 0) begin
            fails++;
            $display("FAIL ddc_data seq %0d word %0d: got 0x%08h, expected 0x%08h",
                     e.seq, bad, ddc_data[32*bad +: 32], e.data[32*bad +: 32]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_reset  = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    hps_read_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_reset = 1'b0;

    check("rst_frame_ready", 64'(frame_ready), 64'd0);
    check("rst_sample_ready", 64'(sample_ready), 64'd1);
    check("rst_frame_seq", 64'(frame_seq), 64'd0);
    check("rst_frame_words", 64'(frame_words), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_time_out", 64'(ddc_time_out), 64'd0);
    check("rst_data_nonzero", 64'(|ddc_data), 64'd0);

    // Frame 1: publishes one edge after the last sample.
    fill(32'h100, 32, 1'b0);
    expect_frame(6'd32, cyc + 1);
    idle(1);
    check("word31_first_frame", 64'(ddc_data[1023:992]), 64'h11F);

    // Frame 2 fills behind the held frame; extra samples are dropped.
    for (int k = 0; k < 10 && !sample_ready; k++) idle(1);
    check("ready_after_publish", 64'(sample_ready), 64'd1);
    fill(32'h120, 32, 1'b0);
    check("ready_low_when_full", 64'(sample_ready), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD_0000 + 32'(i));
    check("drop_count_5", 64'(drop_count), 64'd5);
    check("held_seq", 64'(frame_seq), 64'd1);
    check("held_word0", 64'(ddc_data[31:0]), 64'h100);
    hps_read_bit = ~hps_read_bit;
    idle(1);
    expect_frame(6'd32, cyc + 1);
    check("ack_clears_ready", 64'(frame_ready), 64'd0);
    idle(1);

    // Ack frame 2, then a stray toggle with nothing published.
    hps_read_bit = ~hps_read_bit;
    idle(1);
    check("ack2_clears_ready", 64'(frame_ready), 64'd0);
    hps_read_bit = ~hps_read_bit;
    idle(2);
    check("stray_ack_ready", 64'(frame_ready), 64'd0);
    check("stray_ack_seq", 64'(frame_seq), 64'd2);
    fill(32'h140, 32, 1'b0);
    expect_frame(6'd32, cyc + 1);
    idle(3);
    check("frame3_waits_ack", 64'(frame_ready), 64'd1);

    // Last sample of frame 4 coincides with the ack of frame 3.
    fill(32'h160, 32, 1'b1);
    expect_frame(6'd32, cyc + 1);
    idle(3);
    check("seq_once", 64'(frame_seq), 64'd4);
    check("drop_unchanged", 64'(drop_count), 64'd5);
    drain("drain_main");

    // Timestamp wrap: frame right after reset, then one starting 3 cycles later.
    do_reset();
    fill(32'h300, 32, 1'b0);
    cur_stamp = 26'h3FFFFFE;
    expect_frame(6'd32, cyc + 1);
    drain("drain_wrap_a");
    do_reset();
    idle(3);
    fill(32'h400, 32, 1'b0);
    cur_stamp = 26'h0000001;
    expect_frame(6'd32, cyc + 1);
    drain("drain_wrap_b");

    // Partial frame: flushed when enabled, otherwise held until complete.
    do_reset();
`ifdef DDC_FRAME_FLUSH_EN
    fill(32'h500, 5, 1'b0);
    cur_stamp = 26'h3FFFFFE;
    expect_frame(6'd5, -1);
    drain("drain_flush");
`else
    fill(32'h500, 5, 1'b0);
    idle(40);
    check("partial_not_published", 64'(frame_ready), 64'd0);
    check("partial_seq", 64'(frame_seq), 64'd0);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
